// File: rtl/result_acc_pkg.sv
// Shared types and width helpers for the result accumulator.
// The entry typedef here uses the default widths; the top declares its own parameterised copy.
package result_acc_pkg;

  localparam int DEF_W = 10;
  localparam int DEF_N = 4;

  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  localparam int DEF_SW = sum_width(DEF_W, DEF_N);
  localparam int DEF_CW = $clog2(DEF_N + 1);

  typedef struct packed {
    logic [DEF_SW-1:0] sum;
    logic [DEF_CW-1:0] cnt;
  } acc_entry_t;

endpackage

// File: rtl/result_acc_if.sv
// Sample-input and group-output bundle of the result accumulator.
// The slave modport is the accumulator side; master is the surrounding logic.
interface result_acc_if
  import result_acc_pkg::*;
#(
  parameter int W     = 10,
  parameter int N     = 4,
  parameter int DEPTH = 4
);

  localparam int SW = sum_width(W, N);
  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_cnt;
  logic          overflow;
  logic [LW-1:0] level;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  out_valid, out_sum, out_cnt, overflow, level
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output out_valid, out_sum, out_cnt, overflow, level
  );

endinterface

// File: rtl/result_acc_fifo.sv
// Synchronous FIFO of group entries; occupancy counter separates full from empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module result_acc_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 15,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (level_q == {LW{1'b0}});
  assign full      = (level_q == LW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push_s) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: {EW{1'b0}}};
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      level_q <= {LW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign level = level_q;

endmodule

// File: rtl/result_accumulator.sv
// Sums groups of N adder results (or flushed partial groups) into an output FIFO.
// Groups closing while the FIFO is full and not popping are dropped and flagged.
module result_accumulator
  import result_acc_pkg::*;
#(
  parameter int W     = 10,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  result_acc_if.slave bus
);

  localparam int SW = sum_width(W, N);
  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
  } entry_t;

  logic [SW-1:0] acc_q, acc_d, sample_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          close_s, push_s, pop_s, full_s, empty_s;
  entry_t        push_entry_s, head_s;
  logic [LW-1:0] level_s;

  assign sample_s = bus.in_valid ? SW'(bus.in_data) : {SW{1'b0}};
  assign pop_s    = !empty_s && bus.out_ready;
  assign close_s  = (bus.in_valid && (cnt_q == CW'(N - 1))) ||
                    (bus.flush && ((cnt_q != {CW{1'b0}}) || bus.in_valid));

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    push_s       = 1'b0;
    push_entry_s = '{sum: {SW{1'b0}}, cnt: {CW{1'b0}}};
    if (close_s) begin
      push_s           = 1'b1;
      push_entry_s.sum = acc_q + sample_s;
      push_entry_s.cnt = cnt_q + CW'(bus.in_valid);
      acc_d            = {SW{1'b0}};
      cnt_d            = {CW{1'b0}};
    end else if (bus.in_valid) begin
      acc_d = acc_q + sample_s;
      cnt_d = cnt_q + CW'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
    // A dropped group still clears acc/cnt above; only the flag records it.
    overflow_d = push_s && full_s && !pop_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= {SW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  result_acc_fifo #(
    .DEPTH (DEPTH),
    .EW    (SW + CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  assign bus.out_valid = !empty_s;
  assign bus.out_sum   = head_s.sum;
  assign bus.out_cnt   = head_s.cnt;
  assign bus.overflow  = overflow_q;
  assign bus.level     = level_s;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed plus randomized bench; a queue-based model of groups and FIFO predicts every output.
module tb_result_accumulator;

  localparam int W     = 10;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int grp[$];
  int qs[$];
  int qc[$];
  bit ovf_exp = 1'b0;

  result_acc_if #(.W(W), .N(N), .DEPTH(DEPTH)) bus ();

  result_accumulator #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":out_valid"}, 32'(bus.out_valid), 32'(qs.size() != 0));
    check({tag, ":level"}, 32'(bus.level), 32'(qs.size()));
    check({tag, ":overflow"}, 32'(bus.overflow), 32'(ovf_exp));
    if (qs.size() != 0) begin
      check({tag, ":out_sum"}, 32'(bus.out_sum), 32'(qs[0]));
      check({tag, ":out_cnt"}, 32'(bus.out_cnt), 32'(qc[0]));
    end
  endtask

  task automatic model_reset();
    grp.delete();
    qs.delete();
    qc.delete();
    ovf_exp = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit v, input int d, input bit f, input bit r, input string tag);
    bit pop;
    bit close;
    int sum;
    bus.in_valid  = v;
    bus.in_data   = W'(d);
    bus.flush     = f;
    bus.out_ready = r;
    pop   = (qs.size() != 0) && r;
    close = (v && grp.size() == N - 1) || (f && (grp.size() > 0 || v));
    if (v) grp.push_back(d);
    ovf_exp = 1'b0;
    if (pop) begin
      void'(qs.pop_front());
      void'(qc.pop_front());
    end
    if (close) begin
      sum = 0;
      foreach (grp[i]) sum += grp[i];
      if (qs.size() >= DEPTH) begin
        ovf_exp = 1'b1;
      end else begin
        qs.push_back(sum);
        qc.push_back(grp.size());
      end
      grp.delete();
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":out_sum"}, 32'(bus.out_sum), 32'd0);
    check({tag, ":out_cnt"}, 32'(bus.out_cnt), 32'd0);
    check({tag, ":overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, ":level"}, 32'(bus.level), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1, "seq1234");
    step(1'b0, 0, 1'b0, 1'b1, "seq1234_pop");
    step(1'b0, 0, 1'b0, 1'b1, "seq1234_idle");

    for (int i = 0; i < 4; i++) step(1'b1, 1023, 1'b0, 1'b0, "max");
    check("max_sum_const", 32'(bus.out_sum), 32'd4092);
    step(1'b0, 0, 1'b0, 1'b1, "max_pop");

    step(1'b1, 5, 1'b0, 1'b1, "flush_a");
    step(1'b1, 7, 1'b0, 1'b1, "flush_b");
    step(1'b0, 0, 1'b1, 1'b0, "flush_close");
    check("flush_cnt_const", 32'(bus.out_cnt), 32'd2);
    step(1'b0, 0, 1'b0, 1'b1, "flush_pop");
    step(1'b0, 0, 1'b1, 1'b1, "flush_empty");
    step(1'b0, 0, 1'b0, 1'b1, "flush_empty_idle");

    for (int g = 0; g < 5; g++)
      for (int i = 0; i < 4; i++) step(1'b1, 10 * g + i, 1'b0, 1'b0, "fill");
    check("fill_ovf_pulse", 32'(bus.overflow), 32'd1);
    check("fill_level_const", 32'(bus.level), 32'(DEPTH));
    step(1'b0, 0, 1'b0, 1'b0, "fill_ovf_clear");
    for (int i = 0; i < 3; i++) step(1'b1, 100 + i, 1'b0, 1'b0, "full_pop");
    step(1'b1, 200, 1'b0, 1'b1, "full_pop_close");
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b1, "drain");

    for (int i = 0; i < 8; i++) step(1'b1, 3 + i, 1'b0, 1'b0, "prereset_groups");
    step(1'b1, 9, 1'b0, 1'b0, "prereset_s1");
    step(1'b1, 9, 1'b0, 1'b0, "prereset_s2");
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b1, "postreset");
    step(1'b0, 0, 1'b0, 1'b1, "postreset_pop");

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 1023)),
           $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
